// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one sdram_controller user port between two
// requesters (p0 = CPU path, p1 = accelerator/DMA path), one transaction
// at a time, with a per-transaction watchdog that fails hung accesses.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   pN_req_valid/we/addr/wdata request from port N, held until pN_req_ready
//   pN_req_ready              one-cycle accept pulse
//   pN_rsp_valid/rdata/err    one-cycle completion pulse to the owner only
//   ctrl_user_addr/rw/data_in request fields to the controller, held
//   ctrl_in_valid             one-cycle issue strobe
//   ctrl_data_out/busy/out_valid  controller status and read data
//
// Build option: SDRAM_ARB_RR_EN selects round-robin arbitration.
// Without it port 0 has fixed priority and port 1 can starve.
module sdram_port_arbiter #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int TO_CYCLES = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              p0_req_valid,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_req_ready,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_req_ready,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic [ADDR_W-1:0] ctrl_user_addr,
  output logic              ctrl_rw,
  output logic [DATA_W-1:0] ctrl_data_in,
  output logic              ctrl_in_valid,
  input  logic [DATA_W-1:0] ctrl_data_out,
  input  logic              ctrl_busy,
  input  logic              ctrl_out_valid
);

  localparam int WD_W = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                owner_q;
  logic                rw_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [WD_W-1:0]     wd_q;

  logic any_req;
  logic win;
  logic accept;
  logic in_done;
  logic wd_guard;
  logic wd_last;
  logic done_ok;

  assign any_req = p0_req_valid | p1_req_valid;

`ifdef SDRAM_ARB_RR_EN
  logic rr_last_q;

  // On contention the port that did not win last time goes;
  // a lone requester always wins.
  assign win = (p0_req_valid & p1_req_valid) ? ~rr_last_q
                                               : p1_req_valid;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rr_last_q <= 1'b1;
    end else if (accept) begin
      rr_last_q <= win;
    end
  end
`else
  assign win = ~p0_req_valid;
`endif

  assign accept = (state_q == S_IDLE) & any_req & ~wb_rst_i;
  assign p0_req_ready = accept & ~win;
  assign p1_req_ready = accept & win;

  assign ctrl_in_valid = (state_q == S_ISSUE) & ~ctrl_busy & ~wb_rst_i;

  // wd_q is the index of the current WAIT cycle, starting at 0.
  // Index 0 is the guard cycle where the controller raises busy.
  assign wd_guard = (wd_q == '0);
  assign wd_last  = (wd_q == WD_W'(TO_CYCLES - 1));
  assign done_ok  = ~wd_guard & (rw_q ? ~ctrl_busy : ctrl_out_valid);

  assign ctrl_user_addr = addr_q;
  assign ctrl_rw        = rw_q;
  assign ctrl_data_in   = wdata_q;

  assign in_done      = (state_q == S_DONE);
  assign p0_rsp_valid = in_done & ~owner_q;
  assign p1_rsp_valid = in_done & owner_q;
  assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : '0;
  assign p0_rsp_err   = p0_rsp_valid & err_q;
  assign p1_rsp_err   = p1_rsp_valid & err_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wd_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            owner_q <= win;
            rw_q    <= win ? p1_req_we : p0_req_we;
            addr_q  <= win ? p1_req_addr : p0_req_addr;
            wdata_q <= win ? p1_req_wdata : p0_req_wdata;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!ctrl_busy) begin
            wd_q    <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done_ok) begin
            rdata_q <= rw_q ? '0 : ctrl_data_out;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end else if (wd_last) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed bench for sdram_port_arbiter with a
// simple controller model and a transaction-level reference model.
module tb_sdram_port_arbiter;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          p0_req_valid, p0_req_we;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata;
  logic          p0_req_ready, p0_rsp_valid, p0_rsp_err;
  logic [DW-1:0] p0_rsp_rdata;
  logic          p1_req_valid, p1_req_we;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata;
  logic          p1_req_ready, p1_rsp_valid, p1_rsp_err;
  logic [DW-1:0] p1_rsp_rdata;
  logic [AW-1:0] ctrl_user_addr;
  logic          ctrl_rw, ctrl_in_valid;
  logic [DW-1:0] ctrl_data_in, ctrl_data_out;
  logic          ctrl_busy, ctrl_out_valid;

  sdram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TO_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .ctrl_user_addr(ctrl_user_addr), .ctrl_rw(ctrl_rw),
    .ctrl_data_in(ctrl_data_in), .ctrl_in_valid(ctrl_in_valid),
    .ctrl_data_out(ctrl_data_out), .ctrl_busy(ctrl_busy),
    .ctrl_out_valid(ctrl_out_valid)
  );

  // Controller model: busy for lat cycles after an issue, read data
  // returned with out_valid as busy drops. hang keeps busy high.
  int          lat = 3;
  bit          hang = 1'b0;
  bit          force_busy = 1'b0;
  int          c_cnt;
  logic        c_ov, c_hung, c_rd;
  logic [7:0]  c_a;
  logic [31:0] c_dout;
  logic [31:0] cmem [0:255];

  always @(posedge clk) begin
    if (rst) begin
      c_cnt  <= 0;
      c_ov   <= 1'b0;
      c_hung <= 1'b0;
      c_dout <= '0;
    end else begin
      c_ov <= 1'b0;
      if (ctrl_in_valid && !ctrl_busy) begin
        c_rd <= !ctrl_rw;
        c_a  <= ctrl_user_addr[9:2];
        if (ctrl_rw) cmem[ctrl_user_addr[9:2]] <= ctrl_data_in;
        if (hang) c_hung <= 1'b1;
        else c_cnt <= lat;
      end else if (c_cnt != 0) begin
        c_cnt <= c_cnt - 1;
        if (c_cnt == 1 && c_rd) begin
          c_ov   <= 1'b1;
          c_dout <= cmem[c_a];
        end
      end
      if (!hang) c_hung <= 1'b0;
    end
  end

  assign ctrl_busy      = (c_cnt != 0) | force_busy | c_hung;
  assign ctrl_out_valid = c_ov;
  assign ctrl_data_out  = c_dout;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int iv_cnt = 0;
  always @(posedge clk) if (ctrl_in_valid) iv_cnt <= iv_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction in flight, described by when it
  // was accepted, issued, and when its response is due.
  bit          m_busy = 1'b0, m_issued, m_we, m_port, m_err;
  bit          m_rr_last = 1'b1, post_rst = 1'b0;
  int          m_acc, m_iss, m_due = -1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  always @(negedge clk) begin
    bit e_r0, e_r1, e_iv, e_rv0, e_rv1, w;
    int k;
    if (rst) begin
      m_busy    = 1'b0;
      m_due     = -1;
      m_rr_last = 1'b1;
      post_rst  = 1'b1;
    end else begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      w    = 1'b0;
      if (!m_busy && (p0_req_valid || p1_req_valid)) begin
`ifdef SDRAM_ARB_RR_EN
        w = (p0_req_valid && p1_req_valid) ? !m_rr_last : p1_req_valid;
`else
        w = !p0_req_valid;
`endif
        e_r0 = !w;
        e_r1 = w;
      end
      e_iv  = m_busy && !m_issued && cyc > m_acc && !ctrl_busy;
      e_rv0 = m_busy && cyc == m_due && !m_port;
      e_rv1 = m_busy && cyc == m_due && m_port;
      chk("p0_req_ready", p0_req_ready, e_r0);
      chk("p1_req_ready", p1_req_ready, e_r1);
      chk("ctrl_in_valid", ctrl_in_valid, e_iv);
      chk("p0_rsp_valid", p0_rsp_valid, e_rv0);
      chk("p1_rsp_valid", p1_rsp_valid, e_rv1);
      if (e_rv0 || e_rv1) begin
        chk("own_rsp_err", m_port ? p1_rsp_err : p0_rsp_err, m_err);
        if (!m_we || m_err)
          chk("own_rsp_rdata", m_port ? p1_rsp_rdata : p0_rsp_rdata,
              m_rdata);
        chk("other_rsp_err", m_port ? p0_rsp_err : p1_rsp_err, 0);
        chk("other_rsp_rdata", m_port ? p0_rsp_rdata : p1_rsp_rdata, 0);
      end
      if (m_busy && cyc > m_acc) begin
        chk("ctrl_user_addr", ctrl_user_addr, m_addr);
        chk("ctrl_rw", ctrl_rw, m_we);
        chk("ctrl_data_in", ctrl_data_in, m_wdata);
      end
      if (post_rst) begin
        chk("rst_addr", ctrl_user_addr, 0);
        chk("rst_rw", ctrl_rw, 0);
        chk("rst_data_in", ctrl_data_in, 0);
        chk("rst_rsp", {p0_rsp_valid, p1_rsp_valid, p0_rsp_err,
                        p1_rsp_err}, 0);
        chk("rst_rdata", {p0_rsp_rdata, p1_rsp_rdata}, 0);
        post_rst = 1'b0;
      end
      if (e_r0 || e_r1) begin
        m_busy    = 1'b1;
        m_port    = w;
        m_we      = w ? p1_req_we : p0_req_we;
        m_addr    = w ? p1_req_addr : p0_req_addr;
        m_wdata   = w ? p1_req_wdata : p0_req_wdata;
        m_acc     = cyc;
        m_issued  = 1'b0;
        m_due     = -1;
        m_rr_last = w;
        if (m_we) ref_mem[m_addr] = m_wdata;
      end else if (m_busy) begin
        if (cyc == m_due) begin
          m_busy = 1'b0;
        end else if (!m_issued) begin
          if (e_iv) begin
            m_issued = 1'b1;
            m_iss    = cyc;
          end
        end else if (m_due < 0) begin
          k = cyc - m_iss;
          if (k >= 2 && (m_we ? !ctrl_busy : ctrl_out_valid)) begin
            m_due   = cyc + 1;
            m_err   = 1'b0;
            m_rdata = m_we ? '0
                    : (ref_mem.exists(m_addr) ? ref_mem[m_addr] : '0);
          end else if (k >= TO) begin
            m_due   = cyc + 1;
            m_err   = 1'b1;
            m_rdata = '0;
          end
        end
      end
    end
  end

  task automatic send(input bit port, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int acc);
    if (port) begin
      p1_req_we = we; p1_req_addr = a; p1_req_wdata = d; p1_req_valid = 1;
    end else begin
      p0_req_we = we; p0_req_addr = a; p0_req_wdata = d; p0_req_valid = 1;
    end
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (port ? p1_req_ready : p0_req_ready) begin
        acc = cyc;
        break;
      end
    end
    chk("accept_seen", acc >= 0, 1);
    @(posedge clk);
    #1;
    if (port) p1_req_valid = 0;
    else p0_req_valid = 0;
  endtask

  task automatic wait_rsp(input bit port, output logic [DW-1:0] d,
                          output logic e, output int rc);
    rc = -1;
    d  = '0;
    e  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (port ? p1_rsp_valid : p0_rsp_valid) begin
        d  = port ? p1_rsp_rdata : p0_rsp_rdata;
        e  = port ? p1_rsp_err : p0_rsp_err;
        rc = cyc;
        break;
      end
    end
    chk("rsp_seen", rc >= 0, 1);
  endtask

  initial begin
    int a0, a1, a2, rc, ivc, iv0, n, seen;
    logic [DW-1:0] d;
    logic e;
    bit g [4];
    bit eg [4];
`ifdef SDRAM_ARB_RR_EN
    eg = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    eg = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1;
    p0_req_valid = 0; p0_req_we = 0; p0_req_addr = '0; p0_req_wdata = '0;
    p1_req_valid = 0; p1_req_we = 0; p1_req_addr = '0; p1_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_in_valid", ctrl_in_valid, 0);
    chk("reset_addr", ctrl_user_addr, 0);
    @(posedge clk);
    #1;

    // T1: p0 write then read back
    send(0, 1, 23'h10, 32'hDEAD_BEEF, a0);
    wait_rsp(0, d, e, rc);
    chk("t1_wr_err", e, 0);
    send(0, 0, 23'h10, '0, a1);
    wait_rsp(0, d, e, rc);
    chk("t1_rd_data", d, 32'hDEAD_BEEF);
    chk("t1_rd_err", e, 0);
    chk("t1_read_lat", rc - a1, 6);
    send(0, 1, 23'h40, 32'h1234_5678, a0);
    wait_rsp(0, d, e, rc);
    send(1, 1, 23'h20, 32'hA5A5_0F0F, a0);
    wait_rsp(1, d, e, rc);
    chk("t1_p1_wr_err", e, 0);

    // T2: both ports read, held continuously
    p0_req_we = 0; p0_req_addr = 23'h10; p0_req_valid = 1;
    p1_req_we = 0; p1_req_addr = 23'h20; p1_req_valid = 1;
    n = 0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      @(negedge clk);
      if (p0_req_ready) begin g[n] = 0; n++; end
      else if (p1_req_ready) begin g[n] = 1; n++; end
    end
    @(posedge clk);
    #1 p0_req_valid = 0; p1_req_valid = 0;
    chk("t2_accepts", n, 4);
    for (int i = 0; i < 4; i++) chk("t2_grant", g[i], eg[i]);
    repeat (20) @(posedge clk);
    #1;

    // T4: p1 read while controller is refreshing
    force_busy = 1;
    iv0 = iv_cnt;
    send(1, 0, 23'h40, '0, a0);
    repeat (3) @(posedge clk);
    #1 force_busy = 0;
    ivc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ctrl_in_valid) begin
        ivc = cyc;
        chk("t4_iv_addr", ctrl_user_addr, 23'h40);
        break;
      end
    end
    chk("t4_iv_delay", ivc - a0, 4);
    wait_rsp(1, d, e, rc);
    chk("t4_rd_data", d, 32'h1234_5678);
    chk("t4_iv_pulses", iv_cnt - iv0, 1);
    @(posedge clk);
    #1;

    // T3: controller hangs, watchdog fires
    hang = 1;
    send(0, 0, 23'h10, '0, a0);
    wait_rsp(0, d, e, rc);
    chk("t3_err", e, 1);
    chk("t3_rdata", d, 0);
    chk("t3_timeout_lat", rc - a0, 18);
    @(posedge clk);
    #1 hang = 0;
    send(1, 1, 23'h44, 32'h0000_55AA, a0);
    wait_rsp(1, d, e, rc);
    chk("t3_next_err", e, 0);

    // T5: reset during WAIT of a p0 read
    @(posedge clk);
    #1;
    send(0, 0, 23'h10, '0, a0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("t5_in_valid", ctrl_in_valid, 0);
    chk("t5_addr", ctrl_user_addr, 0);
    chk("t5_p0_rsp", p0_rsp_valid, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p0_rsp_valid) seen++;
    end
    chk("t5_no_p0_rsp", seen, 0);
    @(posedge clk);
    #1;
    send(1, 0, 23'h20, '0, a0);
    wait_rsp(1, d, e, rc);
    chk("t5_p1_data", d, 32'hA5A5_0F0F);
    chk("t5_p1_err", e, 0);
    @(posedge clk);
    #1;

    // T6: back-to-back p1 writes, zero-latency controller
    lat = 0;
    iv0 = iv_cnt;
    send(1, 1, 23'h0, 32'h1111_0000, a0);
    send(1, 1, 23'h4, 32'h2222_0004, a1);
    send(1, 1, 23'h8, 32'h3333_0008, a2);
    wait_rsp(1, d, e, rc);
    chk("t6_gap1", a1 - a0, 5);
    chk("t6_gap2", a2 - a1, 5);
    chk("t6_last_rsp", rc - a2, 4);
    @(posedge clk);
    #1;
    chk("t6_iv_pulses", iv_cnt - iv0, 3);
    lat = 1;
    send(0, 0, 23'h4, '0, a0);
    wait_rsp(0, d, e, rc);
    chk("t6_rd_data", d, 32'h2222_0004);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
